unidade_controle: RTL and testbench
===================================

# unidade_controle

Multi-cycle control unit for the simple 16-bit bus processor. It captures a 9-bit instruction from `DIN` when `Run` is asserted. It then sequences register-file, A-register, G-register and bus-driver enables over 2 to 4 cycles, and drives the 3-bit ALU operation code consumed by the downstream ALU (`sinal_ULA`). It sits directly upstream of the ALU and owns all bus arbitration.

## Interface
Parameters:
- `N_REGS`, 8: number of general registers; select fields are log2(`N_REGS`) = 3 bits.

Ports:
- `Clock`  in  1  single clock; all state updates on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `Run`  in  1  start request, sampled only in state T0.
- `DIN`  in  16  instruction word in T0; `DIN[8:0]` = `III XXX YYY`; immediate data in T1 of `mvi`.
- `IR_in`  out  1  load instruction register from `DIN[8:0]`.
- `R_in`  out  8  one-hot write enable for R0..R7.
- `R_out`  out  8  one-hot bus-drive enable for R0..R7.
- `A_in`  out  1  load register A from the bus.
- `G_in`  out  1  load register G from the ALU result.
- `G_out`  out  1  G drives the bus.
- `DIN_out`  out  1  `DIN` drives the bus.
- `sinal_ULA`  out  3  ALU operation code.
- `Done`  out  1  one-cycle pulse in the final step of an instruction.

## Operation
- Internal state: the step register (T0..T3) and a 9-bit IR (`III`=opcode, `XXX`=Rx, `YYY`=Ry).
- All outputs are decoded combinationally from the step and the IR. Every output is 0 unless listed below.
- While `Reset`=1, every output is forced to 0.
- T0:
  - `IR_in` = `Run`.
  - If `Run`=1, IR <= `DIN[8:0]` and the next step is T1; otherwise stay in T0.
- Opcode 000 `mv Rx,Ry`:
  - T1: `R_out[Ry]`, `R_in[Rx]`, `Done`.
  - Next step T0.
- Opcode 001 `mvi Rx,#D`:
  - T1: `DIN_out`, `R_in[Rx]`, `Done`.
  - Next step T0.
- Opcodes 010..111 (ALU ops):
  - T1: `R_out[Rx]`, `A_in`.
  - T2: `R_out[Ry]`, `G_in`, `sinal_ULA` = opcode − 2.
  - T3: `G_out`, `R_in[Rx]`, `Done`.
  - Next step T0.
- Opcode to ALU code mapping: 010 add→000, 011 sub→001, 100 or→010, 101 slt→011, 110 sll→100, 111 srl→101.
- `sinal_ULA` is 000 outside T2. Codes 110 and 111 are never emitted.
- Bus invariant: at most one of {`R_out` bits, `G_out`, `DIN_out`} is asserted in any cycle.
- `Rx` = `Ry` is legal. For example, `add R3,R3` doubles R3.

## Timing
- Reset values: step = T0, IR = 9'b0, all outputs 0.
- Latency from the `Run` sample edge: `mv`/`mvi` assert `Done` 1 cycle later; ALU ops assert `Done` 3 cycles later.
- Total cycles including T0: 2 for `mv`/`mvi`, 4 for ALU ops.
- `Run` is ignored in T1..T3. A held `Run` starts the next instruction in the T0 following `Done`.
- There is no back-to-back overlap: at least one T0 cycle occurs between instructions.
- `DIN` must hold the immediate during T1 of `mvi`. The upstream instruction source guarantees this.
- Reset mid-instruction: step returns to T0 and IR clears at that edge. No `Done` is produced and no partial register write happens after the reset edge.
- Reset and `Run` in the same cycle: reset wins and IR is not loaded.

## Structure
- Shared package `proc_pkg`:
  - opcode constants (`OP_MV`, `OP_MVI`, `OP_ADD`..`OP_SRL`);
  - ALU code constants (`ULA_ADD`=000 .. `ULA_SRL`=101);
  - step enum (T0..T3).
- The ALU imports the same ALU codes from `proc_pkg`.
- Sub-module `dec3to8`: a 3-bit to one-hot 8-bit decoder with an enable input. It is instantiated twice, once for `R_in` and once for `R_out`.

## Test plan
- Reset: hold `Reset`=1 for 2 cycles with `Run`=1 → all outputs 0 and IR=0; release reset → `IR_in`=1 in T0.
- `mvi R2,#5` (`DIN`=9'b001_010_000, then `DIN`=5) → T1: `DIN_out`=1, `R_in`=8'b0000_0100, `Done`=1; back in T0 on the next cycle.
- `mv R7,R1` (9'b000_111_001) → T1: `R_out`=8'b0000_0010, `R_in`=8'b1000_0000, `Done`=1.
- `sub R0,R3` (9'b011_000_011):
  - T1: `R_out`=8'b0000_0001, `A_in`=1;
  - T2: `R_out`=8'b0000_1000, `G_in`=1, `sinal_ULA`=001;
  - T3: `G_out`=1, `R_in`=8'b0000_0001, `Done`=1.
- Sweep all six ALU opcodes (010..111) → `sinal_ULA` in T2 equals 000..101 in order. Check the bus one-hot invariant every cycle.
- `srl` started, `Reset` asserted in T2 → T0 next cycle, IR=0, no `Done`, and `R_in` never asserted.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared opcode, ALU-code and step definitions for the 16-bit bus processor.
// The ALU imports the same ULA_* codes, so the two blocks cannot drift apart.
package proc_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  localparam logic [2:0] ULA_ADD = 3'b000;
  localparam logic [2:0] ULA_SUB = 3'b001;
  localparam logic [2:0] ULA_OR  = 3'b010;
  localparam logic [2:0] ULA_SLT = 3'b011;
  localparam logic [2:0] ULA_SLL = 3'b100;
  localparam logic [2:0] ULA_SRL = 3'b101;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  // Only ALU opcodes reach this mapping; mv/mvi fall to the default.
  function automatic logic [2:0] ula_code(input logic [2:0] op);
    case (op)
      OP_ADD:  ula_code = ULA_ADD;
      OP_SUB:  ula_code = ULA_SUB;
      OP_OR:   ula_code = ULA_OR;
      OP_SLT:  ula_code = ULA_SLT;
      OP_SLL:  ula_code = ULA_SLL;
      OP_SRL:  ula_code = ULA_SRL;
      default: ula_code = ULA_ADD;
    endcase
  endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-bit select to one-hot 8-bit decoder; all outputs low when disabled.
module dec3to8 (
  input  logic [2:0] sel_i,
  input  logic       en_i,
  output logic [7:0] onehot_o
);

  for (genvar gi = 0; gi < 8; gi++) begin : g_bit
    assign onehot_o[gi] = en_i && (sel_i == 3'(gi));
  end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: latches a 9-bit instruction in T0 and sequences
// register, A, G and bus-driver enables over T1..T3.
module unidade_controle
  import proc_pkg::*;
#(
  parameter int N_REGS = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  input  logic [15:0]       DIN,
  output logic              IR_in,
  output logic [N_REGS-1:0] R_in,
  output logic [N_REGS-1:0] R_out,
  output logic              A_in,
  output logic              G_in,
  output logic              G_out,
  output logic              DIN_out,
  output logic [2:0]        sinal_ULA,
  output logic              Done
);

  step_t       step_q, step_d;
  logic [8:0]  ir_q;
  logic [2:0]  op, rx, ry;
  logic        rin_en, rout_en;
  logic [2:0]  rin_sel, rout_sel;
  logic        unused_din;

  assign op = ir_q[8:6];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];
  // Only the low 9 bits carry the instruction; the immediate goes straight to the bus.
  assign unused_din = ^DIN[15:9];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      if (IR_in) ir_q <= DIN[8:0];
    end
  end

  always_comb begin
    step_d    = step_q;
    IR_in     = 1'b0;
    A_in      = 1'b0;
    G_in      = 1'b0;
    G_out     = 1'b0;
    DIN_out   = 1'b0;
    sinal_ULA = 3'b000;
    Done      = 1'b0;
    rin_en    = 1'b0;
    rout_en   = 1'b0;
    rin_sel   = rx;
    rout_sel  = ry;
    case (step_q)
      T0: begin
        IR_in = Run;
        if (Run) step_d = T1;
      end
      T1: begin
        if (op == OP_MV) begin
          rout_en = 1'b1;
          rin_en  = 1'b1;
          Done    = 1'b1;
          step_d  = T0;
        end else if (op == OP_MVI) begin
          DIN_out = 1'b1;
          rin_en  = 1'b1;
          Done    = 1'b1;
          step_d  = T0;
        end else begin
          rout_sel = rx;
          rout_en  = 1'b1;
          A_in     = 1'b1;
          step_d   = T2;
        end
      end
      T2: begin
        rout_en   = 1'b1;
        G_in      = 1'b1;
        sinal_ULA = ula_code(op);
        step_d    = T3;
      end
      T3: begin
        G_out  = 1'b1;
        rin_en = 1'b1;
        Done   = 1'b1;
        step_d = T0;
      end
    endcase
    // Reset silences every control line, including the one-hot decoders.
    if (Reset) begin
      IR_in     = 1'b0;
      A_in      = 1'b0;
      G_in      = 1'b0;
      G_out     = 1'b0;
      DIN_out   = 1'b0;
      sinal_ULA = 3'b000;
      Done      = 1'b0;
      rin_en    = 1'b0;
      rout_en   = 1'b0;
    end
  end

  dec3to8 u_dec_rin (
    .sel_i    (rin_sel),
    .en_i     (rin_en),
    .onehot_o (R_in)
  );

  dec3to8 u_dec_rout (
    .sel_i    (rout_sel),
    .en_i     (rout_en),
    .onehot_o (R_out)
  );

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench for unidade_controle: stimulus pushes per-cycle expected
// outputs, a negedge monitor pops and compares them and checks bus exclusivity.
module tb_unidade_controle;

  logic        Clock;
  logic        Reset;
  logic        Run;
  logic [15:0] DIN;
  logic        IR_in;
  logic [7:0]  R_in;
  logic [7:0]  R_out;
  logic        A_in;
  logic        G_in;
  logic        G_out;
  logic        DIN_out;
  logic [2:0]  sinal_ULA;
  logic        Done;

  unidade_controle #(.N_REGS(8)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Run       (Run),
    .DIN       (DIN),
    .IR_in     (IR_in),
    .R_in      (R_in),
    .R_out     (R_out),
    .A_in      (A_in),
    .G_in      (G_in),
    .G_out     (G_out),
    .DIN_out   (DIN_out),
    .sinal_ULA (sinal_ULA),
    .Done      (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [24:0] v;
    int          id;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   txn    = 0;

  // {IR_in, R_in, R_out, A_in, G_in, G_out, DIN_out, sinal_ULA, Done}
  function automatic logic [24:0] mk(input logic ir, input logic [7:0] rin,
                                     input logic [7:0] rout, input logic a,
                                     input logic g, input logic gout,
                                     input logic dout, input logic [2:0] ula,
                                     input logic dn);
    mk = {ir, rin, rout, a, g, gout, dout, ula, dn};
  endfunction

  task automatic cyc(input logic rst, input logic run, input logic [15:0] din,
                     input logic [24:0] e);
    exp_t item;
    @(posedge Clock);
    #1;
    Reset = rst;
    Run   = run;
    DIN   = din;
    item.v  = e;
    item.id = txn;
    txn++;
    q.push_back(item);
  endtask

  task automatic check_ir_zero(input string name);
    checks++;
    if (dut.ir_q !== 9'd0) begin
      errors++;
      $display("FAIL %s: ir got %b expected 000000000", name, dut.ir_q);
    end else begin
      $display("ok   %s: ir=%b", name, dut.ir_q);
    end
  endtask

  // Monitor: outputs are presented every cycle, so pop one expectation per negedge.
  always @(negedge Clock) begin
    logic [24:0] act;
    exp_t        e;
    int          drivers;
    act = {IR_in, R_in, R_out, A_in, G_in, G_out, DIN_out, sinal_ULA, Done};
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL cycle%0d: got ir=%b rin=%b rout=%b a=%b g=%b gout=%b dout=%b ula=%b done=%b expected ir=%b rin=%b rout=%b a=%b g=%b gout=%b dout=%b ula=%b done=%b",
                 e.id, act[24], act[23:16], act[15:8], act[7], act[6], act[5], act[4], act[3:1], act[0],
                 e.v[24], e.v[23:16], e.v[15:8], e.v[7], e.v[6], e.v[5], e.v[4], e.v[3:1], e.v[0]);
      end else begin
        $display("ok   cycle%0d: rin=%b rout=%b a=%b g=%b gout=%b dout=%b ula=%b done=%b",
                 e.id, R_in, R_out, A_in, G_in, G_out, DIN_out, sinal_ULA, Done);
      end
      drivers = $countones(R_out) + int'(G_out) + int'(DIN_out);
      checks++;
      if (drivers > 1) begin
        errors++;
        $display("FAIL bus_onehot cycle%0d: got %0d drivers expected <=1", e.id, drivers);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish before 20000");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  localparam logic [24:0] ZERO = 25'd0;
  logic [2:0] ula_tab [6];
  logic [7:0] rx_oh, ry_oh;
  logic [2:0] rx, ry;

  initial begin
    ula_tab[0] = 3'b000; ula_tab[1] = 3'b001; ula_tab[2] = 3'b010;
    ula_tab[3] = 3'b011; ula_tab[4] = 3'b100; ula_tab[5] = 3'b101;

    Reset = 1'b1;
    Run   = 1'b1;
    DIN   = 16'h0055;

    // Reset held two cycles with Run=1: everything zero, IR not loaded
    cyc(1'b1, 1'b1, 16'h0055, ZERO);
    cyc(1'b1, 1'b1, 16'h0055, ZERO);

    // mvi R2,#5
    cyc(1'b0, 1'b1, 16'b001_010_000, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    check_ir_zero("after_reset");
    cyc(1'b0, 1'b0, 16'd5, mk(0, 8'b0000_0100, 8'h00, 0, 0, 0, 1, 3'b000, 1));
    cyc(1'b0, 1'b0, 16'd0, ZERO);

    // mv R7,R1
    cyc(1'b0, 1'b1, 16'b000_111_001, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    cyc(1'b0, 1'b0, 16'd0, mk(0, 8'b1000_0000, 8'b0000_0010, 0, 0, 0, 0, 3'b000, 1));
    cyc(1'b0, 1'b0, 16'd0, ZERO);

    // sub R0,R3
    cyc(1'b0, 1'b1, 16'b011_000_011, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    cyc(1'b0, 1'b0, 16'd0, mk(0, 8'h00, 8'b0000_0001, 1, 0, 0, 0, 3'b000, 0));
    cyc(1'b0, 1'b0, 16'd0, mk(0, 8'h00, 8'b0000_1000, 0, 1, 0, 0, 3'b001, 0));
    cyc(1'b0, 1'b0, 16'd0, mk(0, 8'b0000_0001, 8'h00, 0, 0, 1, 0, 3'b000, 1));

    // ALU sweep with Run held high; junk DIN in T1..T3 must not reload IR
    for (int op = 2; op < 8; op++) begin
      rx = 3'(op);
      ry = (op == 2) ? 3'(op) : 3'(7 - op);
      rx_oh = 8'd1 << rx;
      ry_oh = 8'd1 << ry;
      cyc(1'b0, 1'b1, {7'd0, 3'(op), rx, ry}, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
      cyc(1'b0, 1'b1, 16'hFFFF, mk(0, 8'h00, rx_oh, 1, 0, 0, 0, 3'b000, 0));
      cyc(1'b0, 1'b1, 16'hFFFF, mk(0, 8'h00, ry_oh, 0, 1, 0, 0, ula_tab[op-2], 0));
      cyc(1'b0, 1'b1, 16'hFFFF, mk(0, rx_oh, 8'h00, 0, 0, 1, 0, 3'b000, 1));
    end
    cyc(1'b0, 1'b0, 16'd0, ZERO);

    // srl R5,R6 interrupted by reset in T2
    cyc(1'b0, 1'b1, 16'b111_101_110, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    cyc(1'b0, 1'b0, 16'd0, mk(0, 8'h00, 8'b0010_0000, 1, 0, 0, 0, 3'b000, 0));
    cyc(1'b1, 1'b0, 16'd0, ZERO);
    cyc(1'b0, 1'b0, 16'd0, ZERO);
    check_ir_zero("after_mid_reset");
    cyc(1'b0, 1'b0, 16'd0, ZERO);
    cyc(1'b0, 1'b1, 16'b001_011_000, mk(1, 8'h00, 8'h00, 0, 0, 0, 0, 3'b000, 0));
    cyc(1'b0, 1'b0, 16'd9, mk(0, 8'b0000_1000, 8'h00, 0, 0, 0, 1, 3'b000, 1));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge Clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
